filter_bank_arbiter: RTL
========================

FILTER_BANK_ARBITER -- requirements
Module: filter_bank_arbiter

Interface
REQ-001 Parameter disp_bits, default 5, disparity field width; disp_conf width is 8+disp_bits.
REQ-002 Parameter line_len, default 120, pixels per line.
REQ-003 Parameter max_inflight, default 2, maximum lines accepted into the bank but not yet fully returned.
REQ-004 clk  input  1  clock; all logic on rising edge.
REQ-005 reset  input  1  synchronous, active-high.
REQ-006 req_valid  input  2  per-requester pixel valid (index 0, 1).
REQ-007 req_disp_conf  input  2x(8+disp_bits)  per-requester disparity/confidence pixel.
REQ-008 req_conf  input  2x8  per-requester confidence pixel.
REQ-009 req_ready  output  2  per-requester accept; a pixel transfers when req_valid[r] && req_ready[r].
REQ-010 bank_valid, bank_disp_conf, bank_conf  output  1, 8+disp_bits, 8  pixel stream to the filter bank.
REQ-011 bank_out_valid, bank_disp_conf_out, bank_conf_out  input  1, 8+disp_bits, 8  filtered stream from the bank, exactly line_len valids per input line, in order.
REQ-012 out_valid  output  2  per-requester filtered-pixel valid.
REQ-013 out_disp_conf, out_conf  output  8+disp_bits, 8  shared filtered data, qualified by out_valid.
REQ-014 inflight  output  clog2(max_inflight+1)  lines outstanding.
REQ-015 tag_error  output  1  sticky: bank output arrived with no line owner.

Function
REQ-016 Granularity is one whole line; a grant never changes before line_len pixels of the granted requester are transferred.
REQ-017 States: ST_IDLE, ST_GRANT.
REQ-018 ST_IDLE -> ST_GRANT when any req_valid is high and inflight < max_inflight; grant latched in register gnt.
REQ-019 Round robin: both requesting -> grant the requester not equal to last_gnt; one requesting -> grant it; last_gnt updates at grant.
REQ-020 In ST_IDLE req_ready = 2'b00; in ST_GRANT req_ready[gnt] = 1, other bit 0; req_ready is combinational from state.
REQ-021 Each transfer increments pix_cnt (clog2(line_len) bits); transfer at pix_cnt == line_len-1 clears pix_cnt, pushes gnt into tag FIFO, returns to ST_IDLE.
REQ-022 bank_valid/bank_disp_conf/bank_conf are registered: the transferred pixel appears exactly 1 cycle after the transfer cycle; bank_valid low otherwise.
REQ-023 Tag FIFO depth max_inflight; inflight equals its occupancy; a new grant is never issued when full, so overflow cannot occur.
REQ-024 Output routing is combinational: out_valid[r] = bank_out_valid && tag FIFO non-empty && head == r; out data = bank data passthrough.
REQ-025 out_cnt (clog2(line_len) bits) increments on each routed bank_out_valid; at out_cnt == line_len-1 it clears and pops the tag FIFO.
REQ-026 Push and pop in the same cycle: inflight unchanged, order preserved.
REQ-027 bank_out_valid with tag FIFO empty: out_valid stays 0, out_cnt unchanged, tag_error set until reset.
REQ-028 Requester dropping req_valid mid-line: grant held, pix_cnt held, no timeout.
REQ-029 ST_IDLE with inflight == max_inflight: remain in ST_IDLE until a pop, then grant may issue the following cycle.

Reset
REQ-030 On reset: state ST_IDLE, gnt 0, last_gnt 1 (so requester 0 wins first tie), pix_cnt 0, out_cnt 0, tag FIFO empty, inflight 0, bank_valid 0, req_ready 0, out_valid 0, tag_error 0.
REQ-031 Reset mid-line discards the partial line and all tags; reset is also applied to the bank by the parent so no stale outputs are routed.

Verification
REQ-032 Only requester 1 streams 120 pixels continuously -> 120 bank_valid pulses each 1 cycle after transfer; after bank returns 120 valids, out_valid[1] pulses 120 times, inflight 1 -> 0.
REQ-033 Both requesters valid from reset -> line order 0,1,0,1; req_ready never high on both bits; no line interleaving at bank input.
REQ-034 max_inflight=2, bank output stalled, both requesters always valid -> exactly 2 lines accepted, inflight 2, req_ready 0 until 120 bank outputs return, then 3rd grant.
REQ-035 Bank's last output of line 1 in same cycle as last input of line 3 -> inflight stays 2, line 2 outputs routed to correct owner.
REQ-036 bank_out_valid pulsed with inflight 0 -> out_valid 0, tag_error 1 and remains 1 until reset.
REQ-037 Reset asserted at pix_cnt 60 -> next cycle all outputs at reset values; fresh line from requester 0 accepted starting at pix_cnt 0.

Source files
------------

// File: rtl/filter_bank_arbiter.sv
// Line-granular round-robin arbiter feeding a shared filter bank; a tag FIFO records
// each line's owner so the bank's in-order output stream is routed back to its requester.
module filter_bank_arbiter #(
  parameter int unsigned disp_bits    = 5,
  parameter int unsigned line_len     = 120,
  parameter int unsigned max_inflight = 2
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic [1:0]                          req_valid,
  input  logic [2*(8+disp_bits)-1:0]          req_disp_conf,
  input  logic [15:0]                         req_conf,
  output logic [1:0]                          req_ready,
  output logic                                bank_valid,
  output logic [8+disp_bits-1:0]              bank_disp_conf,
  output logic [7:0]                          bank_conf,
  input  logic                                bank_out_valid,
  input  logic [8+disp_bits-1:0]              bank_disp_conf_out,
  input  logic [7:0]                          bank_conf_out,
  output logic [1:0]                          out_valid,
  output logic [8+disp_bits-1:0]              out_disp_conf,
  output logic [7:0]                          out_conf,
  output logic [$clog2(max_inflight+1)-1:0]   inflight,
  output logic                                tag_error
);

  localparam int unsigned DataW = 8 + disp_bits;
  localparam int unsigned CntW  = (line_len > 1) ? $clog2(line_len) : 1;
  localparam int unsigned InfW  = $clog2(max_inflight + 1);
  localparam logic [CntW-1:0] LastPix = CntW'(line_len - 1);
  localparam logic [InfW-1:0] MaxInf  = InfW'(max_inflight);

  typedef enum logic [0:0] {StIdle, StGrant} state_e;

  state_e                  state_q, state_d;
  logic                    gnt_q, gnt_d;
  logic                    last_gnt_q, last_gnt_d;
  logic [CntW-1:0]         pix_cnt_q, pix_cnt_d;
  logic [CntW-1:0]         out_cnt_q, out_cnt_d;
  logic [max_inflight-1:0] tags_q, tags_d;
  logic [InfW-1:0]         count_q, count_d;
  logic                    tag_error_q;
  logic                    bank_valid_q;
  logic [DataW-1:0]        bank_dc_q;
  logic [7:0]              bank_conf_q;

  logic                    xfer, push, pop, routed, nonempty;
  logic [InfW-1:0]         wr_idx;
  logic [DataW-1:0]        sel_dc;
  logic [7:0]              sel_conf;

  // Arbitration and line-input FSM
  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    last_gnt_d = last_gnt_q;
    pix_cnt_d  = pix_cnt_q;
    req_ready  = 2'b00;
    xfer       = 1'b0;
    push       = 1'b0;
    unique case (state_q)
      StIdle: begin
        if ((|req_valid) && (count_q < MaxInf)) begin
          state_d    = StGrant;
          gnt_d      = (&req_valid) ? ~last_gnt_q : req_valid[1];
          last_gnt_d = gnt_d;
        end
      end
      StGrant: begin
        req_ready[gnt_q] = 1'b1;
        xfer             = req_valid[gnt_q];
        if (xfer) begin
          if (pix_cnt_q == LastPix) begin
            pix_cnt_d = '0;
            push      = 1'b1;
            state_d   = StIdle;
          end else begin
            pix_cnt_d = pix_cnt_q + CntW'(1);
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign sel_dc   = gnt_q ? req_disp_conf[2*DataW-1:DataW] : req_disp_conf[DataW-1:0];
  assign sel_conf = gnt_q ? req_conf[15:8] : req_conf[7:0];

  // Output routing: the FIFO head owns whatever the bank emits next
  assign nonempty  = (count_q != '0);
  assign routed    = bank_out_valid && nonempty;
  assign out_valid = {routed && tags_q[0], routed && !tags_q[0]};
  assign out_disp_conf = bank_disp_conf_out;
  assign out_conf      = bank_conf_out;

  always_comb begin
    out_cnt_d = out_cnt_q;
    pop       = 1'b0;
    if (routed) begin
      if (out_cnt_q == LastPix) begin
        out_cnt_d = '0;
        pop       = 1'b1;
      end else begin
        out_cnt_d = out_cnt_q + CntW'(1);
      end
    end
  end

  // Tag FIFO as a shift register with the head at bit 0
  assign wr_idx = count_q - InfW'(pop);

  always_comb begin
    tags_d = pop ? (tags_q >> 1) : tags_q;
    for (int i = 0; i < int'(max_inflight); i++) begin
      if (push && (InfW'(i) == wr_idx)) begin
        tags_d[i] = gnt_q;
      end
    end
    count_d = count_q + InfW'(push) - InfW'(pop);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      gnt_q        <= 1'b0;
      last_gnt_q   <= 1'b1;
      pix_cnt_q    <= '0;
      out_cnt_q    <= '0;
      tags_q       <= '0;
      count_q      <= '0;
      tag_error_q  <= 1'b0;
      bank_valid_q <= 1'b0;
      bank_dc_q    <= '0;
      bank_conf_q  <= '0;
    end else begin
      state_q      <= state_d;
      gnt_q        <= gnt_d;
      last_gnt_q   <= last_gnt_d;
      pix_cnt_q    <= pix_cnt_d;
      out_cnt_q    <= out_cnt_d;
      tags_q       <= tags_d;
      count_q      <= count_d;
      bank_valid_q <= xfer;
      if (xfer) begin
        bank_dc_q   <= sel_dc;
        bank_conf_q <= sel_conf;
      end
      if (bank_out_valid && !nonempty) begin
        tag_error_q <= 1'b1;
      end
    end
  end

  assign bank_valid     = bank_valid_q;
  assign bank_disp_conf = bank_dc_q;
  assign bank_conf      = bank_conf_q;
  assign inflight       = count_q;
  assign tag_error      = tag_error_q;

endmodule
